// File: rtl/seq_detector_param.sv
// seq_detector_param: Mealy detector for a runtime-loadable PAT_W-bit serial pattern, state on the falling edge.
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             ovl,
  input  logic [PAT_W-1:0] pat,
  input  logic             pat_load,
  output logic             z,
  output logic [CNT_W-1:0] cnt
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  sr;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  preg;
  logic [PAT_W-1:0]  cand;

  // en qualifies d: a bit is consumed on the falling edge only when en=1 and
  // pat_load=0. There is no backpressure; the detector accepts every qualified bit.
  assign cand = {sr, d};
  assign z    = en & ~pat_load & (fill == FILL_MAX) & (cand == preg);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      sr   <= '0;
      fill <= '0;
      preg <= RST_PAT;
    end else if (pat_load) begin
      preg <= pat;
      sr   <= '0;
      fill <= '0;
    end else if (en) begin
      if (z && !ovl) begin
        // Non-overlapping: the next match must be built from PAT_W fresh bits.
        sr   <= '0;
        fill <= '0;
      end else begin
        sr <= cand[PAT_W-2:0];
        if (fill != FILL_MAX) begin
          fill <= fill + FILL_W'(1);
        end
      end
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (z && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule
